// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two valid/ready
// requesters. Round-robin grant, operands latched on acceptance, ALU result
// registered after one EXEC cycle and returned to the granted requester.
module alu_share_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int OP_WIDTH    = 4,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [OP_WIDTH-1:0]    req0_op,
    input  logic [DATA_WIDTH-1:0]  req0_a,
    input  logic [DATA_WIDTH-1:0]  req0_b,
    input  logic [SHAMT_WIDTH-1:0] req0_shamt,

    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [OP_WIDTH-1:0]    req1_op,
    input  logic [DATA_WIDTH-1:0]  req1_a,
    input  logic [DATA_WIDTH-1:0]  req1_b,
    input  logic [SHAMT_WIDTH-1:0] req1_shamt,

    output logic                   rsp0_valid,
    input  logic                   rsp0_ready,
    output logic                   rsp1_valid,
    input  logic                   rsp1_ready,
    output logic [DATA_WIDTH-1:0]  rsp_result,
    output logic                   rsp_zero,

    output logic [OP_WIDTH-1:0]    alu_op,
    output logic [DATA_WIDTH-1:0]  alu_a,
    output logic [DATA_WIDTH-1:0]  alu_b,
    output logic [SHAMT_WIDTH-1:0] alu_shamt,
    input  logic [DATA_WIDTH-1:0]  alu_result,
    input  logic                   alu_zero,

    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   last_grant;
    logic                   grant_id;
    logic                   sel0;
    logic                   sel1;
    logic [OP_WIDTH-1:0]    op_q;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  b_q;
    logic [SHAMT_WIDTH-1:0] shamt_q;

    // Round-robin pick: a lone requester wins, on a tie the one not granted last.
    always_comb begin
        sel0 = req0_valid && (!req1_valid || last_grant);
        sel1 = req1_valid && (!req0_valid || !last_grant);
    end

    // Next-state and handshake outputs; readys only in IDLE, rsp valid only in RESP.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = sel0;
                req1_ready = sel1;
                if (sel0 || sel1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = !grant_id;
                rsp1_valid = grant_id;
                if ((!grant_id && rsp0_ready) || (grant_id && rsp1_ready)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latching on acceptance, grant bookkeeping, result capture after EXEC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            shamt_q    <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (state == IDLE && (sel0 || sel1)) begin
                grant_id   <= sel1;
                last_grant <= sel1;
                op_q       <= sel1 ? req1_op    : req0_op;
                a_q        <= sel1 ? req1_a     : req0_a;
                b_q        <= sel1 ? req1_b     : req0_b;
                shamt_q    <= sel1 ? req1_shamt : req0_shamt;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
        end
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_shamt = shamt_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: behavioural ALU attached to the
// alu_* ports, scoreboard of expected responses pushed at each handshake and
// popped when the response is consumed.
module tb_alu_share_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [4:0]  alu_shamt;
    logic        alu_zero;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    logic gq[$];
    int   gc[$];
    int   cyc = 0;

    alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4), .SHAMT_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    // Reference ALU: AND, OR, NOR, ADD, SUB, left SHIFT; anything else yields 0.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return ~(a | b);
            4'd3:    return a + b;
            4'd4:    return a - b;
            4'd14:   return a << sh;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_op, alu_a, alu_b, alu_shamt);
    assign alu_zero   = (alu_result == 32'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor: records handshakes, checks response latency, hold and payload.
    logic        prev_v;
    logic [31:0] prev_res;
    exp_t        e;
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            prev_v = 1'b0;
        end else begin
            cyc++;
            if (req0_valid && req0_ready) begin
                exp_q.push_back('{1'b0, alu_ref(req0_op, req0_a, req0_b, req0_shamt),
                                  alu_ref(req0_op, req0_a, req0_b, req0_shamt) == 32'd0, cyc});
                gq.push_back(1'b0);
                gc.push_back(cyc);
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back('{1'b1, alu_ref(req1_op, req1_a, req1_b, req1_shamt),
                                  alu_ref(req1_op, req1_a, req1_b, req1_shamt) == 32'd0, cyc});
                gq.push_back(1'b1);
                gc.push_back(cyc);
            end
            if (req0_ready && req1_ready) chk("dual_ready", 32'd1, 32'd0);
            if (rsp0_valid || rsp1_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    if (!prev_v) chk("rsp_latency", cyc - e.cyc, 32'd2);
                    else         chk("rsp_hold", rsp_result, prev_res);
                    chk("rsp_excl", {31'd0, rsp0_valid && rsp1_valid}, 32'd0);
                    chk("rsp_id", {31'd0, rsp1_valid}, {31'd0, e.id});
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        chk("rsp_result", rsp_result, e.res);
                        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_v   = rsp0_valid || rsp1_valid;
            prev_res = rsp_result;
        end
    end

    task automatic send(input logic id, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
        logic got;
        if (!id) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_shamt = sh;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_shamt = sh;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) got = 1'b1;
        end
        if (!got) chk("req_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!id) req0_valid = 1'b0;
        else     req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic seen;
        reset = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_shamt = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_shamt = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_req_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_zero", {31'd0, rsp_zero}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic operations through each requester.
        send(1'b0, 4'd3, 32'd5, 32'd7, 5'd0);
        wait_idle();
        send(1'b1, 4'd4, 32'd9, 32'd9, 5'd0);
        wait_idle();
        send(1'b1, 4'd7, 32'd3, 32'd4, 5'd0);
        wait_idle();
        send(1'b0, 4'd2, 32'h0F0F_0000, 32'h0000_00FF, 5'd0);
        wait_idle();

        // Contention right after reset: alternation starting with req0, one grant per 3 cycles.
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        gq.delete(); gc.delete();
        req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'd10; req0_b = 32'd3; req0_shamt = 5'd0;
        req1_valid = 1'b1; req1_op = 4'd4; req1_a = 32'd10; req1_b = 32'd3; req1_shamt = 5'd0;
        for (int i = 0; i < 40 && gq.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        chk("rr_count", gq.size(), 32'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++) begin
            chk("rr_order", {31'd0, gq[i]}, i % 2);
            if (i > 0) chk("rr_spacing", gc[i] - gc[i-1], 32'd3);
        end

        // Backpressure on requester 0 with requester 1 waiting.
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        send(1'b0, 4'd3, 32'd100, 32'd23, 5'd0);
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'hA0; req1_b = 32'h0B; req1_shamt = 5'd0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rsp0_valid) seen = 1'b1;
        end
        chk("bp_rsp_seen", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
            chk("bp_result", rsp_result, 32'd123);
            chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_busy", {31'd0, busy}, 32'd0);
        chk("bp_release_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("bp_req1_accept", {31'd0, req1_ready}, 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_idle();

        // SHIFT: b is latched unchanged even though the ALU ignores it.
        send(1'b0, 4'd14, 32'd1, 32'h55, 5'd31);
        chk("shift_alu_b", alu_b, 32'h55);
        chk("shift_alu_shamt", {27'd0, alu_shamt}, 32'd31);
        chk("shift_alu_op", {28'd0, alu_op}, 32'd14);
        wait_idle();

        // Reset during EXEC aborts the operation and restores req0 priority.
        send(1'b0, 4'd3, 32'd40, 32'd2, 5'd3);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("abort_result", rsp_result, 32'd0);
        chk("abort_zero", {31'd0, rsp_zero}, 32'd0);
        chk("abort_alu_a", alu_a, 32'd0);
        chk("abort_alu_shamt", {27'd0, alu_shamt}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'hFF; req0_b = 32'h0F; req0_shamt = 5'd0;
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'h1;  req1_b = 32'h2;  req1_shamt = 5'd0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                seen = 1'b1;
                chk("abort_next_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
            end
        end
        if (!seen) chk("abort_grant_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        repeat (2) @(negedge clk);
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters (e.g. main datapath and branch/address unit) using valid/ready handshakes.
- Round-robin grant, operand latching, and sequencing of the ALU through a fixed IDLE → EXEC → RESP cycle.
- The registered result and zero flag are returned to the granted requester with backpressure support.
- Sits between the requesters and the ALU instance; it drives the ALU operation, operand and shift-amount inputs, and samples its result and zero outputs.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the ALU.
- OP_WIDTH, 4, ALU operation code width.
- SHAMT_WIDTH, 5, shift amount width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  arbiter accepts requester 0's operation this cycle.
- req0_op  input  OP_WIDTH  operation code (AND=0, OR=1, NOR=2, ADD=3, SUB=4, SHIFT=14).
- req0_a  input  DATA_WIDTH  operand A.
- req0_b  input  DATA_WIDTH  operand B.
- req0_shamt  input  SHAMT_WIDTH  shift amount.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_shamt: same as the req0_* ports, for requester 1.
- rsp0_valid  output  1  result available for requester 0.
- rsp0_ready  input  1  requester 0 consumes the result.
- rsp1_valid  output  1  result available for requester 1.
- rsp1_ready  input  1  requester 1 consumes the result.
- rsp_result  output  DATA_WIDTH  registered ALU result (shared by both requesters).
- rsp_zero  output  1  registered ALU zero flag.
- alu_op  output  OP_WIDTH  to ALU operation input.
- alu_a  output  DATA_WIDTH  to ALU operand A.
- alu_b  output  DATA_WIDTH  to ALU operand B.
- alu_shamt  output  SHAMT_WIDTH  to ALU shift amount.
- alu_result  input  DATA_WIDTH  from ALU result.
- alu_zero  input  1  from ALU zero flag.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - All latched operand/op/shamt registers = 0.
  - rsp_result=0, rsp_zero=0.
  - rsp0_valid=rsp1_valid=0, busy=0.
- Ready signals:
  - reqN_ready is combinational and high only in IDLE for the selected requester.
  - At most one ready is high in any cycle.
- Selection in IDLE:
  - If only one requester is valid, it is selected.
  - If both are valid, select the requester that is not last_grant.
  - No valid request: stay in IDLE, no ready asserted.
- IDLE → EXEC on handshake (valid & ready):
  - Latch op, a, b and shamt into the ALU-drive registers.
  - Record grant_id and set last_grant=grant_id.
- EXEC (exactly 1 cycle):
  - alu_* ports present the latched values.
  - At the cycle end, register rsp_result←alu_result and rsp_zero←alu_zero; go to RESP.
- alu_* outputs are always driven from the latched registers; outside EXEC they hold the last values, or 0 after reset.
- RESP:
  - rsp<grant_id>_valid=1; the other requester's rsp valid stays 0.
  - rsp_result and rsp_zero are held stable while valid.
  - When rsp<grant_id>_ready=1: drop valid next cycle and go to IDLE.
  - Otherwise hold indefinitely; no new request is accepted.
- Latency and throughput:
  - Handshake at cycle t → rsp valid at t+2.
  - Earliest next acceptance is t+3 when the response is consumed at t+2.
  - Throughput: 1 operation per 3 cycles.
- Boundary and corner cases:
  - Undefined op codes are passed through unchanged; the ALU returns 0, so rsp_result=0 and rsp_zero=1.
  - SHIFT ignores operand b; the arbiter still latches it unchanged.
  - A requester dropping valid before its handshake is legal; no state changes.
  - reqN_valid while the other requester is in EXEC or RESP waits; its inputs must stay stable until ready.
  - rspN_ready asserted while rspN_valid=0 is ignored.
  - Reset in EXEC or RESP aborts the operation: no response is issued, and last_grant returns to 1.

Test Plan:
- ADD via req0 (a=5, b=7, op=3): handshake at t → rsp0_valid at t+2, rsp_result=12, rsp_zero=0; rsp1_valid stays 0.
- SUB via req1 (a=9, b=9, op=4) → rsp1_valid, rsp_result=0, rsp_zero=1; SHIFT (a=1, shamt=31, op=14) → rsp_result=0x80000000.
- Both valid right after reset with rsp_ready tied high → grant order req0, req1, req0, req1; one acceptance every 3 cycles.
- Backpressure: hold rsp0_ready=0 for 5 cycles → rsp0_valid and rsp_result held stable, req1_ready stays 0, busy=1; release → IDLE the following cycle.
- Undefined op=7 (a=3, b=4) → rsp_result=0, rsp_zero=1.
- Assert reset during EXEC → all outputs return to reset values immediately; no rsp_valid afterwards; the next simultaneous request grants req0.
